sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised N-channel sram-like arbiter/merger. Connects several CPU-side sram-like masters (inst fetch, data, future uncached/prefetch ports) to one downstream sram-like slave, e.g. the AXI bridge.
- Tracks outstanding transactions in issue order, so each data_ok/rdata is routed back to the channel that issued it.
- Replaces per-port dedicated bridges. The CPU top instantiates it once between the pipeline and the bus bridge.

Parameters:
- NUM_CH, 2, number of master channels (1..8); channel 0 is inst.
- OUTSTANDING, 4, maximum accepted-but-unanswered transactions (power of 2, 2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_req  in  NUM_CH  per-channel request
- m_wr  in  NUM_CH  per-channel write flag
- m_size  in  2*NUM_CH  per-channel size; channel i at [2i+1:2i]
- m_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes
- m_addr  in  NUM_CH*ADDR_W  per-channel address
- m_wdata  in  NUM_CH*DATA_W  per-channel write data
- m_addr_ok  out  NUM_CH  per-channel address accept
- m_data_ok  out  NUM_CH  per-channel response
- m_rdata  out  DATA_W  read data, broadcast to all channels; qualified by m_data_ok
- s_req  out  1  slave request
- s_wr  out  1  slave write flag
- s_size  out  2  slave size
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_addr_ok  in  1  slave address accept
- s_data_ok  in  1  slave response
- s_rdata  in  DATA_W  slave read data
- busy  out  1  outstanding count nonzero
- resp_err  out  1  sticky: s_data_ok seen with nothing outstanding

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous, active-high. All state (lock, FIFO pointers, count, RR pointer, resp_err) clears on reset.
- Reset values: s_req=0, m_addr_ok=0, m_data_ok=0, busy=0, resp_err=0.
- Master protocol rule: a master holds m_req and its payload stable until it sees m_addr_ok.
- Arbitration when unlocked:
  - Select the winner among asserted m_req (policy below) combinationally.
  - Drive s_req=1 with the winner's payload, unless the order FIFO is full.
- Lock:
  - If s_req=1 and s_addr_ok=0, register the winner as locked.
  - While locked, the payload mux selects the locked channel regardless of other requests.
  - Lock clears on the s_addr_ok handshake.
- Address handshake (s_req & s_addr_ok):
  - m_addr_ok[winner]=1 in the same cycle (combinational passthrough); all other m_addr_ok bits are 0.
  - Push the winner id into the order FIFO, depth OUTSTANDING, width clog2(NUM_CH), minimum 1.
- Full FIFO:
  - s_req=0 and no new push.
  - A pop in the same cycle does not unblock; the request issues the next cycle. This keeps the timing path free of s_data_ok.
- Response (s_data_ok):
  - FIFO non-empty: m_data_ok[head]=1 and m_rdata=s_rdata in the same cycle; pop.
  - FIFO empty: no m_data_ok; set resp_err.
- Simultaneous push and pop when not full: count unchanged; both pointers advance.
- Pointers wrap modulo OUTSTANDING. Count is clog2(OUTSTANDING)+1 bits.
- Zero-latency response (s_data_ok in the same cycle as its own addr handshake) is not supported. The slave guarantees data_ok at least 1 cycle after addr_ok.
- Mid-operation reset: outstanding ids are discarded. Late s_data_ok after reset sets resp_err.
- busy = (count != 0).

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - Round-robin arbitration. A pointer register holds the last granted channel; search starts at pointer+1 and wraps.
  - The pointer updates only on the address handshake.
- Not defined: fixed priority, lowest index wins; channel 0 (inst) highest. No pointer register.

Decomposition:
- Shared package/header: `SRAM_LIKE_SIZE_WORD 2'b10, `SRAM_LIKE_SIZE_HALF 2'b01, `SRAM_LIKE_SIZE_BYTE 2'b00, and the clog2 helper macro.
- One natural sub-module: sram_like_order_fifo, a parametrised id FIFO with push, pop, full, empty, head and count.

Test Plan:
- Single read: ch0 req addr 0x1FC00000, slave addr_ok cycle 1, data_ok cycle 3 with 0xDEADBEEF -> m_addr_ok=2'b01 cycle 1; m_data_ok=2'b01 and m_rdata=0xDEADBEEF cycle 3; busy 1 during cycles 2-3.
- Contention, fixed priority: ch0 and ch1 assert together, slave addr_ok every cycle -> ch0 granted cycle 0, ch1 cycle 1. Responses arriving in order route to 01 then 10.
- Contention with SRAM_ARB_RR_EN: both channels continuously requesting for 4 handshakes -> grant sequence 0,1,0,1.
- Lock: ch1 wins, slave holds addr_ok=0 for 3 cycles, ch0 raises req meanwhile -> s_addr stays ch1's address; ch1 accepted first.
- Full: OUTSTANDING=4, 4 handshakes with no data_ok -> s_req=0 on the 5th request. After one data_ok, the 5th issues the following cycle.
- Error/reset: s_data_ok with the FIFO empty -> no m_data_ok; resp_err=1 and stays set. Reset with 2 outstanding -> busy=0, resp_err=0.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: bus size encodings,
// the id-width helper and the address-phase lock state type.
// Optional feature macro used by the top: SRAM_ARB_RR_EN.

`ifndef SRAM_LIKE_ARBITER_DEFS
`define SRAM_LIKE_ARBITER_DEFS
`define SRAM_LIKE_SIZE_WORD 2'b10
`define SRAM_LIKE_SIZE_HALF 2'b01
`define SRAM_LIKE_SIZE_BYTE 2'b00
// Bit width needed to index n items, never less than one bit.
`define SRAM_LIKE_CLOG2(n) (((n) <= 1) ? 1 : $clog2(n))
`endif

package sram_like_arbiter_pkg;

    // Address phase: open for arbitration, or held on one channel until
    // the slave accepts it.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Width of a channel id; a single-channel build still gets one bit.
    function automatic int clog2_min1(input int n);
        return `SRAM_LIKE_CLOG2(n);
    endfunction

endpackage

// File: rtl/sram_like_order_fifo.sv
// In-order id FIFO: remembers which channel issued each accepted address
// so responses can be routed back in issue order.

module sram_like_order_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,   // power of 2
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_id_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [WIDTH-1:0]        head_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Overflow and underflow requests are ignored rather than corrupting state.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy registers; pointers wrap modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, matching real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Id storage.
    // NOTE: the storage array has no reset; entries are only read after being
    // written, so clearing them would just add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter/merger: picks one master per address phase,
// forwards it to a single sram-like slave, and routes each response back to
// the issuing channel in order.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority with channel 0 (inst) highest.

module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          m_req,
    input  logic [NUM_CH-1:0]          m_wr,
    input  logic [2*NUM_CH-1:0]        m_size,
    input  logic [NUM_CH*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]   m_addr,
    input  logic [NUM_CH*DATA_W-1:0]   m_wdata,
    output logic [NUM_CH-1:0]          m_addr_ok,
    output logic [NUM_CH-1:0]          m_data_ok,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [DATA_W-1:0]          s_rdata,
    output logic                       busy,
    output logic                       resp_err
);

    localparam int ID_W   = clog2_min1(NUM_CH);
    localparam int CNT_W  = $clog2(OUTSTANDING) + 1;
    localparam int STRB_W = DATA_W / 8;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    lock_id_q, lock_id_d;
    logic               resp_err_q, resp_err_d;

    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic               handshake;
    logic               pop;

    logic               fifo_full, fifo_empty;
    logic [ID_W-1:0]    fifo_head;
    logic [CNT_W-1:0]   fifo_count;

`ifdef SRAM_ARB_RR_EN
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    // Round-robin pick: search from last grant + 1, wrapping. Iterating from
    // the far end lets the nearest requester overwrite earlier candidates.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        arb_valid = 1'b0;
        arb_id    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (m_req[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                arb_valid = 1'b1;
                arb_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    // Pointer moves to the granted channel only when the slave accepts it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) rr_ptr_d = grant_id;
    end

    // Reset to the last channel so the first search starts at channel 0.
    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= ID_W'(NUM_CH - 1);
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority pick: lowest requesting index wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_id    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                arb_valid = 1'b1;
                arb_id    = ID_W'(i);
            end
        end
    end
`endif

    // A stalled address phase stays on its channel until accepted, so the
    // payload seen by the slave never changes mid-request.
    assign grant_id    = (state_q == ST_LOCKED) ? lock_id_q : arb_id;
    assign grant_valid = (state_q == ST_LOCKED) | arb_valid;

    // A full FIFO blocks issue regardless of a same-cycle pop, keeping
    // s_data_ok out of the s_req path.
    assign s_req     = grant_valid & ~fifo_full;
    assign handshake = s_req & s_addr_ok;
    assign pop       = s_data_ok & ~fifo_empty;

    // Payload mux driven by the granted channel.
    always_comb begin
        s_wr    = m_wr[grant_id];
        s_size  = m_size[grant_id*2 +: 2];
        s_wstrb = m_wstrb[grant_id*STRB_W +: STRB_W];
        s_addr  = m_addr[grant_id*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[grant_id*DATA_W +: DATA_W];
    end

    // Per-channel handshakes: address accept to the winner, response to the
    // oldest outstanding id.
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_addr_ok[i] = handshake & (grant_id == ID_W'(i));
            m_data_ok[i] = pop & (fifo_head == ID_W'(i));
        end
    end

    assign m_rdata = s_rdata;

    // Lock next-state: enter on a stalled request, leave on acceptance.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ST_OPEN: begin
                if (s_req && !s_addr_ok) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = grant_id;
                end
            end
            ST_LOCKED: begin
                if (handshake) state_d = ST_OPEN;
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // A response with nothing outstanding is a protocol error; it is sticky.
    always_comb begin
        resp_err_d = resp_err_q | (s_data_ok & fifo_empty);
    end

    // Lock and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            lock_id_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
    assign busy     = (fifo_count != '0);

    sram_like_order_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ID_W)
    ) u_order_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (handshake),
        .push_id_i (grant_id),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a scoreboard: stimulus queues the
// expected grant/response, a negedge monitor pops and compares whenever the
// DUT raises m_addr_ok or m_data_ok. Expectations follow SRAM_ARB_RR_EN.

module tb_sram_like_arbiter;

    localparam int NUM_CH      = 2;
    localparam int OUTSTANDING = 4;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;

    localparam logic [31:0] ADDR0 = 32'h1FC0_0000;
    localparam logic [31:0] ADDR1 = 32'h8000_1000;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_CH-1:0]          m_req;
    logic [NUM_CH-1:0]          m_wr;
    logic [2*NUM_CH-1:0]        m_size;
    logic [NUM_CH*DATA_W/8-1:0] m_wstrb;
    logic [NUM_CH*ADDR_W-1:0]   m_addr;
    logic [NUM_CH*DATA_W-1:0]   m_wdata;
    logic [NUM_CH-1:0]          m_addr_ok;
    logic [NUM_CH-1:0]          m_data_ok;
    logic [DATA_W-1:0]          m_rdata;
    logic                       s_req;
    logic                       s_wr;
    logic [1:0]                 s_size;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_addr_ok;
    logic                       s_data_ok;
    logic [DATA_W-1:0]          s_rdata;
    logic                       busy;
    logic                       resp_err;

    typedef struct {
        logic [NUM_CH-1:0] onehot;
        logic [31:0]       word;
    } exp_t;

    exp_t addr_q[$];
    exp_t resp_q[$];
    exp_t mon_e;

    int tests_run    = 0;
    int tests_failed = 0;

    sram_like_arbiter #(
        .NUM_CH      (NUM_CH),
        .OUTSTANDING (OUTSTANDING),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .s_req     (s_req),
        .s_wr      (s_wr),
        .s_size    (s_size),
        .s_wstrb   (s_wstrb),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .s_rdata   (s_rdata),
        .busy      (busy),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_CH-1:0] oh(input int ch);
        return NUM_CH'(1) << ch;
    endfunction

    function automatic logic [31:0] ch_addr(input int ch);
        return (ch == 0) ? ADDR0 : ADDR1;
    endfunction

    // Monitor: compares every presented handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_addr_ok != '0) begin
                if (addr_q.size() == 0) begin
                    check("unexpected m_addr_ok", 64'(m_addr_ok), 64'd0);
                end else begin
                    mon_e = addr_q.pop_front();
                    check("grant m_addr_ok", 64'(m_addr_ok), 64'(mon_e.onehot));
                    check("grant s_addr", 64'(s_addr), 64'(mon_e.word));
                end
            end
            if (m_data_ok != '0) begin
                if (resp_q.size() == 0) begin
                    check("unexpected m_data_ok", 64'(m_data_ok), 64'd0);
                end else begin
                    mon_e = resp_q.pop_front();
                    check("resp m_data_ok", 64'(m_data_ok), 64'(mon_e.onehot));
                    check("resp m_rdata", 64'(m_rdata), 64'(mon_e.word));
                end
            end
        end
    end

    initial begin : stimulus
        int first, second, last;
        int g[5];
        logic [31:0] dat[5];

        reset     = 1'b1;
        m_req     = '0;
        m_wr      = 2'b10;
        m_size    = {2'b01, 2'b10};
        m_wstrb   = {4'b0011, 4'b1111};
        m_addr    = {ADDR1, ADDR0};
        m_wdata   = {32'h0000_CAFE, 32'h1111_1111};
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset s_req", 64'(s_req), 64'd0);
        check("reset m_addr_ok", 64'(m_addr_ok), 64'd0);
        check("reset m_data_ok", 64'(m_data_ok), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset resp_err", 64'(resp_err), 64'd0);
        step();

        // Single read on ch0: addr_ok cycle 1, data_ok cycle 3.
        m_req = 2'b01;
        @(negedge clk);
        check("t1 s_req", 64'(s_req), 64'd1);
        check("t1 s_addr", 64'(s_addr), 64'(ADDR0));
        step();
        addr_q.push_back('{oh(0), ADDR0});
        s_addr_ok = 1'b1;
        step();
        m_req = '0;
        s_addr_ok = 1'b0;
        @(negedge clk);
        check("t1 busy c2", 64'(busy), 64'd1);
        check("t1 no early data_ok", 64'(m_data_ok), 64'd0);
        step();
        resp_q.push_back('{oh(0), 32'hDEAD_BEEF});
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1 busy c3", 64'(busy), 64'd1);
        step();
        s_data_ok = 1'b0;
        @(negedge clk);
        check("t1 idle busy", 64'(busy), 64'd0);
        step();

        // Contention: both request together, slave accepts every cycle.
`ifdef SRAM_ARB_RR_EN
        first = 1;   // last grant was ch0
`else
        first = 0;
`endif
        second = 1 - first;
        m_req = 2'b11;
        s_addr_ok = 1'b1;
        addr_q.push_back('{oh(first), ch_addr(first)});
        step();
        m_req[first] = 1'b0;
        addr_q.push_back('{oh(second), ch_addr(second)});
        step();
        m_req = '0;
        s_addr_ok = 1'b0;
        resp_q.push_back('{oh(first), 32'hA5A5_0001});
        s_data_ok = 1'b1;
        s_rdata   = 32'hA5A5_0001;
        step();
        resp_q.push_back('{oh(second), 32'hA5A5_0002});
        s_rdata = 32'hA5A5_0002;
        step();
        s_data_ok = 1'b0;

        // Full FIFO from a clean reset, both masters requesting continuously.
        reset = 1'b1;
        step();
        reset = 1'b0;
        last = NUM_CH - 1;
        for (int k = 0; k < 5; k++) begin
`ifdef SRAM_ARB_RR_EN
            g[k] = (last + 1) % NUM_CH;
            last = g[k];
`else
            g[k] = 0;
`endif
            dat[k] = 32'h5000_0000 + 32'(k);
        end
        m_req = 2'b11;
        s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_q.push_back('{oh(g[k]), ch_addr(g[k])});
            @(negedge clk);
            check("full fill s_req", 64'(s_req), 64'd1);
            step();
        end
        @(negedge clk);
        check("full blocks s_req", 64'(s_req), 64'd0);
        check("full busy", 64'(busy), 64'd1);
        step();
        resp_q.push_back('{oh(g[0]), dat[0]});
        s_data_ok = 1'b1;
        s_rdata   = dat[0];
        @(negedge clk);
        check("full pop same cycle s_req", 64'(s_req), 64'd0);
        step();
        s_data_ok = 1'b0;
        addr_q.push_back('{oh(g[4]), ch_addr(g[4])});
        @(negedge clk);
        check("full 5th issues", 64'(s_req), 64'd1);
        step();
        m_req = '0;
        s_addr_ok = 1'b0;
        for (int k = 1; k < 5; k++) begin
            resp_q.push_back('{oh(g[k]), dat[k]});
            s_data_ok = 1'b1;
            s_rdata   = dat[k];
            step();
        end
        s_data_ok = 1'b0;
        @(negedge clk);
        check("full drained busy", 64'(busy), 64'd0);
        step();

        // Lock: ch1 stalls for 3 cycles while ch0 joins.
        m_req = 2'b10;
        @(negedge clk);
        check("lock s_addr c0", 64'(s_addr), 64'(ADDR1));
        check("lock s_wr", 64'(s_wr), 64'd1);
        check("lock s_size", 64'(s_size), 64'd1);
        check("lock s_wstrb", 64'(s_wstrb), 64'h3);
        check("lock s_wdata", 64'(s_wdata), 64'h0000_CAFE);
        step();
        m_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("lock s_addr held", 64'(s_addr), 64'(ADDR1));
            check("lock s_req held", 64'(s_req), 64'd1);
            step();
        end
        s_addr_ok = 1'b1;
        addr_q.push_back('{oh(1), ADDR1});
        step();
        m_req = 2'b01;
        addr_q.push_back('{oh(0), ADDR0});
        step();
        m_req = '0;
        s_addr_ok = 1'b0;
        resp_q.push_back('{oh(1), 32'h0BAD_F00D});
        s_data_ok = 1'b1;
        s_rdata   = 32'h0BAD_F00D;
        step();
        resp_q.push_back('{oh(0), 32'h1234_5678});
        s_rdata = 32'h1234_5678;
        step();
        s_data_ok = 1'b0;

        // Stray response with nothing outstanding.
        s_data_ok = 1'b1;
        s_rdata   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("err no m_data_ok", 64'(m_data_ok), 64'd0);
        check("err not yet set", 64'(resp_err), 64'd0);
        step();
        s_data_ok = 1'b0;
        @(negedge clk);
        check("err set", 64'(resp_err), 64'd1);
        step();
        @(negedge clk);
        check("err sticky", 64'(resp_err), 64'd1);
        step();

        // Reset with two outstanding discards them; a late response errors.
        m_req = 2'b01;
        s_addr_ok = 1'b1;
        addr_q.push_back('{oh(0), ADDR0});
        step();
        addr_q.push_back('{oh(0), ADDR0});
        step();
        m_req = '0;
        s_addr_ok = 1'b0;
        @(negedge clk);
        check("rst busy before", 64'(busy), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst busy cleared", 64'(busy), 64'd0);
        check("rst resp_err cleared", 64'(resp_err), 64'd0);
        step();
        s_data_ok = 1'b1;
        @(negedge clk);
        check("late m_data_ok", 64'(m_data_ok), 64'd0);
        step();
        s_data_ok = 1'b0;
        @(negedge clk);
        check("late resp_err", 64'(resp_err), 64'd1);
        step();

        check("grants all seen", 64'(addr_q.size()), 64'd0);
        check("responses all seen", 64'(resp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
